// File: rtl/cpu9_pkg.sv
// Shared CPU-wide address types: instruction address and page-offset widths.
package cpu9_pkg;

  localparam int unsigned ADDR_W = 10;
  localparam int unsigned PAGE_W = 8;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [PAGE_W-1:0] page_off_t;

endpackage

// File: rtl/link_stack_mem.sv
// Return-address register file: one synchronous write port, one asynchronous read port.
module link_stack_mem #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 10
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [AW-1:0]            wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [AW-1:0]            rdata
);

  logic [AW-1:0] mem [DEPTH];

  // Contents need no reset; validity is tracked by the owner's depth count.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/link_stack.sv
// Hardware return-address stack feeding the PC's rl input.
// Optional macro LINK_STACK_WRAP_EN: circular storage, push while full overwrites the oldest entry.
module link_stack
  import cpu9_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = ADDR_W,
  parameter int unsigned PW    = PAGE_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       push,
  input  logic                       pop,
  input  logic [AW-1:0]              rp,
  output logic [AW-1:0]              rl,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] depth,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int unsigned PTRW = $clog2(DEPTH);
  localparam int unsigned DW   = $clog2(DEPTH + 1);
  localparam logic [DW-1:0]   DepthOne = DW'(1);
  localparam logic [DW-1:0]   DepthMax = DW'(DEPTH);
  localparam logic [PTRW-1:0] PtrOne   = PTRW'(1);

  logic [DW-1:0]   depth_q, depth_d;
  logic            ovf_q, ovf_d;
  logic            unf_q, unf_d;
  logic [PTRW-1:0] base;
  logic [PTRW-1:0] waddr, raddr;
  logic            we;
  logic [AW-1:0]   ret;
  logic [AW-1:0]   rdata;

`ifdef LINK_STACK_WRAP_EN
  logic [PTRW-1:0] base_q, base_d;
  assign base = base_q;
`else
  assign base = '0;
`endif

  // Page bits are kept; only the in-page offset increments and wraps.
  assign ret = {rp[AW-1:PW], rp[PW-1:0] + 1'b1};

  assign empty = (depth_q == '0);
  assign full  = (depth_q == DepthMax);

  // When full the low depth bits are zero, so the write slot is the oldest entry.
  assign waddr = base + depth_q[PTRW-1:0];
  assign raddr = waddr - PtrOne;

  always_comb begin
    depth_d = depth_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    we      = 1'b0;
`ifdef LINK_STACK_WRAP_EN
    base_d  = base_q;
`endif
    if (push) begin
      if (!full) begin
        we      = 1'b1;
        depth_d = depth_q + DepthOne;
      end else begin
        ovf_d = 1'b1;
`ifdef LINK_STACK_WRAP_EN
        we     = 1'b1;
        base_d = base_q + PtrOne;
`endif
      end
    end else if (pop) begin
      if (!empty) begin
        depth_d = depth_q - DepthOne;
      end else begin
        unf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || start) begin
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
`ifdef LINK_STACK_WRAP_EN
      base_q  <= '0;
`endif
    end else begin
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
`ifdef LINK_STACK_WRAP_EN
      base_q  <= base_d;
`endif
    end
  end

  link_stack_mem #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_mem (
    .clk  (clk),
    .we   (we),
    .waddr(waddr),
    .wdata(ret),
    .raddr(raddr),
    .rdata(rdata)
  );

  assign rl        = empty ? '0 : rdata;
  assign depth     = depth_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule
